// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first; done pulses WIDTH cycles after the accepting edge.
// start is sampled only in IDLE (ignored while busy or done); Diff/Bout hold until the next completion.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             br_nxt;
   logic             last_slice;

   // One full-subtractor slice on the current LSBs of the operand shifters.
   assign d_bit      = a_sh[0] ^ b_sh[0] ^ br;
   assign br_nxt     = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   assign last_slice = (cnt == LAST);

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last_slice) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         Diff   <= '0;
         Bout   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= A;
                  b_sh   <= B;
                  br     <= Bin;
                  res_sh <= '0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= {d_bit, res_sh[WIDTH-1:1]};
               br     <= br_nxt;
               cnt    <= cnt + CW'(1);
               // Final slice: publish the full result on the same edge that enters DONE.
               if (last_slice) begin
                  Diff <= {d_bit, res_sh[WIDTH-1:1]};
                  Bout <= br_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8: vector table plus reset and start-while-busy sequences.
module tb_serial_subtractor;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       Bin;
   logic       busy;
   logic       done;
   logic [7:0] Diff;
   logic       Bout;

   int n_chk;
   int n_fail;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bout  (Bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] exp_diff, input logic exp_bout);
      int busy_cycles;
      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         if (busy) busy_cycles++;
         @(posedge clk); #1;
      end
      check("busy_cycles", busy_cycles, 8);
      check("done_high", done, 1);
      check("diff", Diff, exp_diff);
      check("bout", Bout, exp_bout);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
   endtask

   initial begin
      int cnt_b;
      int cnt_d;
      n_chk  = 0;
      n_fail = 0;

      vecs[0] = '{8'h3C, 8'h15, 1'b0, 8'h27, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
      vecs[4] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1};
      vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
      vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
      vecs[8] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};
      vecs[9] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};

      // Reset asserted before any clock edge.
      reset = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", Diff, 8'h00);
      check("rst_bout", Bout, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout);
      end

      // start and operand changes while busy must not disturb the running operation.
      @(negedge clk);
      A = 8'h50; B = 8'h10; Bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_diff_in_shift", Diff, 8'h00);
      @(negedge clk);
      A = 8'h01; B = 8'h02; Bin = 1'b1; start = 1'b1;
      @(negedge clk);
      A = 8'hEE; B = 8'h77;
      @(negedge clk);
      start = 1'b0;
      cnt_d = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) begin
            cnt_d++;
            check("busy_diff", Diff, 8'h40);
            check("busy_bout", Bout, 0);
         end
      end
      check("busy_single_done", cnt_d, 1);
      check("busy_no_second_op", busy, 0);

      // Reset in the 4th SHIFT cycle abandons the operation.
      @(negedge clk);
      A = 8'h55; B = 8'h11; Bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      check("mid_busy", busy, 1);
      check("mid_hold_diff", Diff, 8'h40);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_diff", Diff, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      cnt_b = 0;
      cnt_d = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (busy) cnt_b++;
         if (done) cnt_d++;
      end
      check("post_rst_no_done", cnt_d, 0);
      check("post_rst_no_busy", cnt_b, 0);
      do_op(8'h0A, 8'h03, 1'b0, 8'h07, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
